// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl
// Sequencer for the single-port tag RAM of a direct-mapped cache. One RAM
// port is shared by three activities: CPU lookups (read tag, compare),
// miss fills (wait for the line data, then validate the tag) and
// whole-cache invalidation (sweep every entry to zero). The RAM has a
// registered read with 2-edge latency: the address is captured on edge E0
// and the output register loads on E1, so the compare happens on E2.
//
// Ports
//   i_clk               clock, all state on the rising edge
//   i_reset_n           asynchronous active-low reset
//   i_req / i_req_addr  lookup request and its {tag, index}
//   o_ready             request can be accepted this cycle
//   o_hit / o_miss      one-cycle lookup result pulses
//   o_fill_req          level, line fill wanted until i_fill_done
//   i_fill_done         pulse, fill data written, tag may be validated
//   i_flush             pulse, invalidate all lines
//   o_busy              controller is not idle
//   o_tag_*             tag RAM address / write data / write enable
//   i_tag_read_data     tag RAM read data, MSB = valid
module cache_tag_ctrl #(
  parameter int TAG_WIDTH   = 20,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_req,
  input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] i_req_addr,
  output logic                           o_ready,
  output logic                           o_hit,
  output logic                           o_miss,
  output logic                           o_fill_req,
  input  logic                           i_fill_done,
  input  logic                           i_flush,
  output logic                           o_busy,
  output logic [INDEX_WIDTH-1:0]         o_tag_address,
  output logic [TAG_WIDTH:0]             o_tag_write_data,
  output logic                           o_tag_write_enable,
  input  logic [TAG_WIDTH:0]             i_tag_read_data
);

  localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic [2:0] {
    SWEEP,
    IDLE,
    RD1,
    RD2,
    FILL,
    WRITE
  } state_t;

  state_t                  state_reg, state_next;
  logic [INDEX_WIDTH-1:0]  sweep_cnt_reg;
  logic                    flush_pending_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    hit_reg, miss_reg;
  logic                    write_enable_next;
  logic                    sweep_last;
  logic                    lookup_hit;
  logic                    accept;

  wire [INDEX_WIDTH-1:0] latched_index = addr_reg[INDEX_WIDTH-1:0];
  wire [TAG_WIDTH-1:0]   latched_tag   = addr_reg[ADDR_WIDTH-1:INDEX_WIDTH];

  assign sweep_last = (state_reg == SWEEP) && (sweep_cnt_reg == LAST_INDEX);
  assign lookup_hit = i_tag_read_data[TAG_WIDTH] &&
                      (i_tag_read_data[TAG_WIDTH-1:0] == latched_tag);

  // A flush arriving in IDLE must block the same-cycle request, hence the
  // combinational i_flush term.
  assign o_ready    = (state_reg == IDLE) && !flush_pending_reg && !i_flush;
  assign accept     = i_req && o_ready;
  assign o_busy     = (state_reg != IDLE);
  assign o_fill_req = (state_reg == FILL);
  assign o_hit      = hit_reg;
  assign o_miss     = miss_reg;
  // The reset state is SWEEP; keep the RAM write quiet while reset is held
  // so the first real sweep write happens in the first cycle after release.
  assign o_tag_write_enable = write_enable_next && i_reset_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= SWEEP;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    o_tag_address     = latched_index;
    o_tag_write_data  = '0;
    write_enable_next = 1'b0;
    case (state_reg)
      SWEEP: begin
        o_tag_address     = sweep_cnt_reg;
        write_enable_next = 1'b1;
        if (sweep_last) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        // Present the incoming index straight away so the RAM captures it
        // on the accepting edge.
        o_tag_address = i_req_addr[INDEX_WIDTH-1:0];
        if (flush_pending_reg || i_flush) begin
          state_next = SWEEP;
        end else if (i_req) begin
          state_next = RD1;
        end
      end
      RD1: begin
        state_next = RD2;
      end
      RD2: begin
        state_next = lookup_hit ? IDLE : FILL;
      end
      FILL: begin
        if (i_fill_done) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        o_tag_write_data  = {1'b1, latched_tag};
        write_enable_next = 1'b1;
        state_next        = IDLE;
      end
      default: begin
        state_next = SWEEP;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sweep_cnt_reg     <= '0;
      flush_pending_reg <= 1'b0;
      addr_reg          <= '0;
      hit_reg           <= 1'b0;
      miss_reg          <= 1'b0;
    end else begin
      if (state_reg == SWEEP) begin
        sweep_cnt_reg <= sweep_last ? '0 : sweep_cnt_reg + 1'b1;
      end
      // Flushes seen while busy collapse into one pending sweep; finishing
      // a sweep satisfies every flush requested before it.
      if (sweep_last) begin
        flush_pending_reg <= 1'b0;
      end else if (i_flush && state_reg != IDLE) begin
        flush_pending_reg <= 1'b1;
      end
      if (accept) begin
        addr_reg <= i_req_addr;
      end
      hit_reg  <= (state_reg == RD2) && lookup_hit;
      miss_reg <= (state_reg == RD2) && !lookup_hit;
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
module tb_cache_tag_ctrl;

  localparam int TW    = 20;
  localparam int IW    = 7;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [TW+IW-1:0] req_addr;
  logic          ready, hit, miss, fill_req, fill_done, flush, busy;
  logic [IW-1:0] tag_addr;
  logic [TW:0]   wdata;
  logic          we;
  logic [TW:0]   rdata;

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;

  // Reference model: what each cache line should hold.
  bit          ref_valid [DEPTH];
  logic [TW-1:0] ref_tag [DEPTH];

  always #5 clk = ~clk;

  cache_tag_ctrl #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW)) dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_req              (req),
    .i_req_addr         (req_addr),
    .o_ready            (ready),
    .o_hit              (hit),
    .o_miss             (miss),
    .o_fill_req         (fill_req),
    .i_fill_done        (fill_done),
    .i_flush            (flush),
    .o_busy             (busy),
    .o_tag_address      (tag_addr),
    .o_tag_write_data   (wdata),
    .o_tag_write_enable (we),
    .i_tag_read_data    (rdata)
  );

  // Tag RAM: address captured on one edge, output register on the next.
  // Contents are scrambled with valid garbage while reset is held.
  logic [TW:0]   ram [DEPTH];
  logic [IW-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= {1'b1, TW'($urandom)};
    end else if (we) begin
      ram[tag_addr] <= wdata;
    end
    ram_addr_q <= tag_addr;
    rdata      <= ram[ram_addr_q];
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end
  endtask

  // Called just before the edge that enters SWEEP; samples every sweep cycle.
  task automatic sweep_check(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (!(we === 1'b1 && tag_addr === IW'(i) && wdata === '0 &&
            busy === 1'b1 && ready === 1'b0 && fill_req === 1'b0)) bad++;
    end
    chk({name, "_sweep_writes"}, bad, 0);
    @(negedge clk);
    chk({name, "_ready_after_sweep"}, ready, 1);
    chk({name, "_idle_after_sweep"}, busy, 0);
    chk({name, "_we_after_sweep"}, we, 0);
    model_clear();
    $display("txn %0d sweep %s complete", txn++, name);
  endtask

  // Starts at a negedge in IDLE. flush_mode: number of flush pulses during FILL.
  task automatic lookup(input logic [TW-1:0] tg, input logic [IW-1:0] idx,
                        input int fill_wait, input int flush_mode, input bit abort);
    bit exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    int wait_c  = (fill_wait < flush_mode) ? flush_mode : fill_wait;
    chk("ready_before_req", ready, 1);
    req      = 1'b1;
    req_addr = {tg, idx};
    #1 chk("idle_addr_route", tag_addr, idx);
    @(negedge clk);
    req       = 1'b0;
    req_addr  = (TW+IW)'($urandom);
    fill_done = 1'($urandom_range(0, 1));
    chk("rd1_busy", busy, 1);
    chk("rd1_addr_held", tag_addr, idx);
    chk("rd1_no_result", {hit, miss}, 0);
    @(negedge clk);
    fill_done = 1'b0;
    chk("rd2_no_result", {hit, miss}, 0);
    chk("rd2_we", we, 0);
    @(negedge clk);
    chk("result_hit", hit, exp_hit);
    chk("result_miss", miss, !exp_hit);
    if (exp_hit) begin
      chk("hit_no_fill", fill_req, 0);
      chk("hit_ready", ready, 1);
      @(negedge clk);
      chk("hit_pulse_width", hit, 0);
      $display("txn %0d lookup tag=%h idx=%0d expect=hit", txn++, tg, idx);
      return;
    end
    chk("miss_fill_req", fill_req, 1);
    chk("fill_addr", tag_addr, idx);
    for (int w = 0; w < wait_c; w++) begin
      flush = (flush_mode >= 1 && w == 0) || (flush_mode >= 2 && w == 1);
      @(negedge clk);
      flush = 1'b0;
      chk("fill_req_held", fill_req, 1);
      chk("miss_pulse_width", miss, 0);
      chk("fill_not_ready", ready, 0);
    end
    if (abort) begin
      $display("txn %0d lookup tag=%h idx=%0d expect=miss (left in fill)", txn++, tg, idx);
      return;
    end
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    chk("write_we", we, 1);
    chk("write_addr", tag_addr, idx);
    chk("write_data", wdata, {1'b1, tg});
    chk("write_fill_req_drop", fill_req, 0);
    chk("write_no_pulse", {hit, miss}, 0);
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tg;
    @(negedge clk);
    chk("post_write_idle", busy, 0);
    chk("post_write_no_hit", hit, 0);
    chk("post_write_ready", ready, flush_mode == 0);
    $display("txn %0d lookup tag=%h idx=%0d expect=miss fill_wait=%0d flushes=%0d",
             txn++, tg, idx, wait_c, flush_mode);
    if (flush_mode != 0) sweep_check("flush_in_fill");
  endtask

  task automatic flush_with_req(input logic [TW-1:0] tg, input logic [IW-1:0] idx);
    req      = 1'b1;
    req_addr = {tg, idx};
    flush    = 1'b1;
    #1 chk("flush_req_ready_low", ready, 0);
    @(posedge clk);
    #1;
    req   = 1'b0;
    flush = 1'b0;
    $display("txn %0d flush with simultaneous request tag=%h idx=%0d", txn++, tg, idx);
    sweep_check("flush_req");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] pool [3];
    pool[0] = 20'hABCDE;
    pool[1] = 20'h12345;
    pool[2] = 20'h0F0F0;
    rst_n = 1'b0; req = 1'b0; req_addr = '0; fill_done = 1'b0; flush = 1'b0;
    model_clear();
    #3;
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    chk("rst_fill_req", fill_req, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_we", we, 0);
    chk("rst_addr", tag_addr, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    sweep_check("init");

    // Directed: miss/fill, hit, alias, invalid line.
    lookup(20'hABCDE, 7'd5, 2, 0, 1'b0);
    lookup(20'hABCDE, 7'd5, 0, 0, 1'b0);
    lookup(20'h12345, 7'd5, 1, 0, 1'b0);
    lookup(20'hABCDE, 7'd6, 0, 0, 1'b0);
    // Flush beats a same-cycle request; line 5 gone afterwards.
    flush_with_req(20'h12345, 7'd5);
    lookup(20'h12345, 7'd5, 0, 0, 1'b0);
    // Two flushes during FILL collapse into a single sweep after WRITE.
    lookup(20'h54321, 7'd9, 3, 2, 1'b0);
    lookup(20'h54321, 7'd9, 1, 1, 1'b0);
    // Asynchronous reset in the middle of a fill.
    lookup(20'hABCDE, 7'd5, 2, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_fill_req", fill_req, 0);
    chk("rst_mid_busy", busy, 1);
    chk("rst_mid_we", we, 0);
    chk("rst_mid_addr", tag_addr, 0);
    chk("rst_mid_ready", ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    sweep_check("rst_mid_fill");
    lookup(20'hABCDE, 7'd5, 0, 0, 1'b0);

    // Randomized lookups over a few indices and tags so hits and aliases occur.
    for (int n = 0; n < 40; n++) begin
      logic [TW-1:0] tg;
      logic [IW-1:0] idx;
      int r = $urandom_range(0, 19);
      tg  = ($urandom_range(0, 3) == 3) ? TW'($urandom) : pool[$urandom_range(0, 2)];
      idx = ($urandom_range(0, 4) == 4) ? IW'($urandom) : IW'($urandom_range(4, 7));
      if (r == 0) begin
        flush_with_req(tg, idx);
      end else if (r == 1) begin
        // Stray fill_done in IDLE must be ignored.
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        chk("stray_fill_done_idle", busy, 0);
        chk("stray_fill_done_ready", ready, 1);
      end else begin
        lookup(tg, idx, $urandom_range(0, 3), (r == 2) ? 1 : (r == 3) ? 2 : 0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Sequencer for a direct-mapped cache's single-port tag RAM.
- RAM: one entry per line, entry = {valid, tag}; registered read, 2-edge read latency.
- Serializes CPU lookups, miss fills and whole-cache invalidation onto the one RAM port.
- Sits between the cache front end and the tag RAM instance.

Parameters:
- TAG_WIDTH, 20, tag bits per entry; RAM data width = TAG_WIDTH+1 (MSB = valid).
- INDEX_WIDTH, 7, line index bits; RAM depth = 2**INDEX_WIDTH.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  lookup request.
- i_req_addr  in  TAG_WIDTH+INDEX_WIDTH  {tag, index} of lookup.
- o_ready  out  1  high only in IDLE with no pending flush; i_req accepted on an edge where i_req & o_ready.
- o_hit  out  1  one-cycle lookup-hit pulse.
- o_miss  out  1  one-cycle lookup-miss pulse.
- o_fill_req  out  1  level: line fill requested, held until i_fill_done.
- i_fill_done  in  1  pulse: fill data written, tag may be validated.
- i_flush  in  1  pulse: invalidate all lines.
- o_busy  out  1  high in any state but IDLE.
- o_tag_address  out  INDEX_WIDTH  tag RAM address.
- o_tag_write_data  out  TAG_WIDTH+1  tag RAM write data.
- o_tag_write_enable  out  1  tag RAM write enable.
- i_tag_read_data  in  TAG_WIDTH+1  tag RAM read data.

Behaviour:
- States: SWEEP, IDLE, RD1, RD2, FILL, WRITE.
- Reset (async, any state): state=SWEEP, sweep counter=0, flush_pending=0, latched addr=0.
- Reset output values: o_hit=0, o_miss=0, o_fill_req=0, o_ready=0, o_busy=1, o_tag_write_enable=0 (then 1 in first SWEEP cycle), o_tag_address=0.
- SWEEP:
  - Each cycle: o_tag_address=counter, o_tag_write_data=0, o_tag_write_enable=1.
  - Counter increments every cycle.
  - After writing index 2**INDEX_WIDTH-1: clear counter and flush_pending, go to IDLE.
  - Duration exactly 2**INDEX_WIDTH cycles; no wrap or duplicate writes.
- IDLE:
  - o_tag_address = index of i_req_addr, combinational, so the RAM captures it on the accepting edge E0.
  - Priority: flush_pending or i_flush goes to SWEEP; else accepted i_req latches i_req_addr and goes to RD1.
  - Simultaneous i_flush and i_req: flush wins; o_ready is low that cycle, so the request is not accepted.
- RD1 (after E0): o_tag_address holds latched index; wait. RAM output register loads at E1.
- RD2 (after E1):
  - hit = i_tag_read_data[MSB] & (i_tag_read_data[TAG_WIDTH-1:0] == latched tag).
  - At E2: register o_hit=hit or o_miss=!hit.
  - Next state: IDLE on hit, FILL on miss.
  - o_hit/o_miss are high exactly during the cycle after E2; both are never high together.
- FILL:
  - o_fill_req=1, o_tag_address=latched index.
  - On i_fill_done go to WRITE; o_fill_req drops the same edge.
  - i_fill_done outside FILL is ignored.
- WRITE:
  - One cycle: o_tag_address=latched index, o_tag_write_data={1, latched tag}, o_tag_write_enable=1.
  - Then IDLE. No hit pulse; the requester re-issues.
- i_flush outside IDLE: sets flush_pending and never interrupts RD/FILL/WRITE. flush_pending is serviced on IDLE entry, and o_ready stays low until the sweep completes.
- Multiple flush pulses while pending: collapse into one sweep.
- o_tag_write_enable is high only in SWEEP and WRITE.
- i_req_addr is ignored except on the accepting edge.

Test Plan:
- Reset release, INDEX_WIDTH=7 -> o_busy high 128 cycles; writes of 0 to addresses 0..127 in order; then o_ready=1.
- Lookup 0x00ABCDE_05 after sweep -> o_miss pulse 2 edges after accept; o_fill_req=1. Then i_fill_done -> one write of {1,0xABCDE} at index 5. Re-lookup -> o_hit pulse.
- After previous: lookup tag 0x12345, index 5 -> o_miss (alias). Lookup tag 0xABCDE, index 6 -> o_miss (invalid line).
- i_flush in the same cycle as i_req in IDLE -> request not accepted; 128-cycle sweep. Later lookup of index 5 -> o_miss.
- i_flush during FILL -> fill completes, WRITE occurs, then immediate sweep; o_ready low until sweep completes.
- i_reset_n asserted mid-FILL -> o_fill_req=0 immediately (async). After release, full sweep restarts from index 0.
